// File: rtl/icb_splt_2s_if.sv
// ICB bus bundle (command + response channels) shared by the splitter's initiator and target sides.
interface icb_splt_2s_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_read;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_err;
  logic [DW-1:0]   rsp_rdata;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/icb_splt_2s.sv
// ICB 1-to-2 address-decoding splitter with an in-order target-ID FIFO for responses.
// Optional feature macro: MYRISCV_ICB_SPLT_ERR_EN (unmapped addresses answered with an error locally).
module icb_splt_2s #(
  parameter int            AW      = 32,
  parameter int            DW      = 32,
  parameter int            FIFO_DP = 4,
  parameter logic [AW-1:0] R0_BASE = AW'(32'h8000_0000),
  parameter logic [AW-1:0] R0_MASK = AW'(32'hF000_0000),
  parameter logic [AW-1:0] R1_BASE = AW'(32'h1000_0000),
  parameter logic [AW-1:0] R1_MASK = AW'(32'hF000_0000)
) (
  input  logic        clk,
  input  logic        rst,
  icb_splt_2s_if.slave  i_icb,
  icb_splt_2s_if.master o0_icb,
  icb_splt_2s_if.master o1_icb
);

  typedef enum logic [1:0] {
    SEL_T0  = 2'd0,
    SEL_T1  = 2'd1,
    SEL_ERR = 2'd2
  } sel_t;

  localparam int PW = (FIFO_DP > 1) ? $clog2(FIFO_DP) : 1;
  localparam int CW = $clog2(FIFO_DP + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DP);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DP - 1);

`ifdef MYRISCV_ICB_SPLT_ERR_EN
  localparam sel_t MISS_SEL = SEL_ERR;
`else
  localparam sel_t MISS_SEL = SEL_T1;
`endif

  sel_t          fifo_q [FIFO_DP];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  sel_t          last_sel;

  sel_t sel;
  sel_t head;
  logic hit0;
  logic hit1;
  logic busy;
  logic stall;
  logic tgt_ready;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Region decode; an address outside R0 falls to target 1 unless the error path is built in.
  always_comb begin
    hit0 = (i_icb.cmd_addr & R0_MASK) == R0_BASE;
    hit1 = (i_icb.cmd_addr & R1_MASK) == R1_BASE;
    if (hit0)      sel = SEL_T0;
    else if (hit1) sel = SEL_T1;
    else           sel = MISS_SEL;
  end

  assign head  = fifo_q[rd_ptr];
  assign busy  = (cnt != '0);
  assign stall = (cnt == CNT_FULL) | (busy & (sel != last_sel));

  always_comb begin
    case (sel)
      SEL_T0:  tgt_ready = o0_icb.cmd_ready;
      SEL_T1:  tgt_ready = o1_icb.cmd_ready;
      default: tgt_ready = 1'b1;
    endcase
  end

  assign i_icb.cmd_ready  = !stall & tgt_ready;
  assign o0_icb.cmd_valid = i_icb.cmd_valid & (sel == SEL_T0) & !stall;
  assign o1_icb.cmd_valid = i_icb.cmd_valid & (sel == SEL_T1) & !stall;

  assign o0_icb.cmd_read  = i_icb.cmd_read;
  assign o0_icb.cmd_addr  = i_icb.cmd_addr;
  assign o0_icb.cmd_wdata = i_icb.cmd_wdata;
  assign o0_icb.cmd_wmask = i_icb.cmd_wmask;
  assign o1_icb.cmd_read  = i_icb.cmd_read;
  assign o1_icb.cmd_addr  = i_icb.cmd_addr;
  assign o1_icb.cmd_wdata = i_icb.cmd_wdata;
  assign o1_icb.cmd_wmask = i_icb.cmd_wmask;

  // Only the FIFO head target may talk back; everything else is held off.
  always_comb begin
    i_icb.rsp_valid  = 1'b0;
    i_icb.rsp_err    = 1'b0;
    i_icb.rsp_rdata  = '0;
    o0_icb.rsp_ready = 1'b0;
    o1_icb.rsp_ready = 1'b0;
    if (busy) begin
      case (head)
        SEL_T0: begin
          i_icb.rsp_valid  = o0_icb.rsp_valid;
          i_icb.rsp_err    = o0_icb.rsp_err;
          i_icb.rsp_rdata  = o0_icb.rsp_rdata;
          o0_icb.rsp_ready = i_icb.rsp_ready;
        end
        SEL_T1: begin
          i_icb.rsp_valid  = o1_icb.rsp_valid;
          i_icb.rsp_err    = o1_icb.rsp_err;
          i_icb.rsp_rdata  = o1_icb.rsp_rdata;
          o1_icb.rsp_ready = i_icb.rsp_ready;
        end
        default: begin
          i_icb.rsp_valid = 1'b1;
          i_icb.rsp_err   = 1'b1;
        end
      endcase
    end
  end

  assign push = i_icb.cmd_valid & i_icb.cmd_ready;
  assign pop  = i_icb.rsp_valid & i_icb.rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      last_sel <= SEL_T0;
    end else begin
      if (push) begin
        wr_ptr   <= ptr_inc(wr_ptr);
        last_sel <= sel;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // Entry storage needs no reset: cnt gates every read of it.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= sel;
  end

endmodule

// File: tb/tb_icb_splt_2s.sv
// Directed self-checking bench for icb_splt_2s; the bench plays both the initiator and the two targets.
module tb_icb_splt_2s;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  icb_splt_2s_if #(.AW(32), .DW(32)) i_icb ();
  icb_splt_2s_if #(.AW(32), .DW(32)) o0_icb ();
  icb_splt_2s_if #(.AW(32), .DW(32)) o1_icb ();

  icb_splt_2s #(.AW(32), .DW(32), .FIFO_DP(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_icb  (i_icb),
    .o0_icb (o0_icb),
    .o1_icb (o1_icb)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic read, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wmask);
    i_icb.cmd_valid = valid;
    i_icb.cmd_read  = read;
    i_icb.cmd_addr  = addr;
    i_icb.cmd_wdata = wdata;
    i_icb.cmd_wmask = wmask;
  endtask

  // Advance one clock; stimulus and checks happen 2ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setRsp0(input logic valid, input logic err, input logic [31:0] rdata);
    o0_icb.rsp_valid = valid;
    o0_icb.rsp_err   = err;
    o0_icb.rsp_rdata = rdata;
  endtask

  task automatic setRsp1(input logic valid, input logic err, input logic [31:0] rdata);
    o1_icb.rsp_valid = valid;
    o1_icb.rsp_err   = err;
    o1_icb.rsp_rdata = rdata;
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    i_icb.rsp_ready  = 1'b1;
    o0_icb.cmd_ready = 1'b1;
    o1_icb.cmd_ready = 1'b1;
    setRsp0(1'b0, 1'b0, 32'h0);
    setRsp1(1'b0, 1'b0, 32'h0);

    #12;
    checkOutput("rst_rsp_valid", 32'(i_icb.rsp_valid), 32'd0);
    checkOutput("rst_o0_rsp_ready", 32'(o0_icb.rsp_ready), 32'd0);
    checkOutput("rst_o1_rsp_ready", 32'(o1_icb.rsp_ready), 32'd0);
    checkOutput("rst_cmd_ready", 32'(i_icb.cmd_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();

    // Read to target 0
    applyStimulus(1'b1, 1'b1, 32'h8000_0004, 32'h0, 4'h0);
    #1;
    checkOutput("t1_o0_cmd_valid", 32'(o0_icb.cmd_valid), 32'd1);
    checkOutput("t1_o1_cmd_valid", 32'(o1_icb.cmd_valid), 32'd0);
    checkOutput("t1_cmd_ready", 32'(i_icb.cmd_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setRsp0(1'b1, 1'b0, 32'h1234_5678);
    #1;
    checkOutput("t1_rsp_valid", 32'(i_icb.rsp_valid), 32'd1);
    checkOutput("t1_rsp_rdata", i_icb.rsp_rdata, 32'h1234_5678);
    checkOutput("t1_rsp_err", 32'(i_icb.rsp_err), 32'd0);
    checkOutput("t1_o0_rsp_ready", 32'(o0_icb.rsp_ready), 32'd1);
    tick();
    setRsp0(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("t1_rsp_idle", 32'(i_icb.rsp_valid), 32'd0);

    // Write to target 1, error response
    applyStimulus(1'b1, 1'b0, 32'h1000_0010, 32'hDEAD_BEEF, 4'b0011);
    #1;
    checkOutput("t2_o1_cmd_valid", 32'(o1_icb.cmd_valid), 32'd1);
    checkOutput("t2_o0_cmd_valid", 32'(o0_icb.cmd_valid), 32'd0);
    checkOutput("t2_o1_addr", o1_icb.cmd_addr, 32'h1000_0010);
    checkOutput("t2_o1_wdata", o1_icb.cmd_wdata, 32'hDEAD_BEEF);
    checkOutput("t2_o1_wmask", 32'(o1_icb.cmd_wmask), 32'h3);
    checkOutput("t2_o1_read", 32'(o1_icb.cmd_read), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setRsp1(1'b1, 1'b1, 32'h0);
    #1;
    checkOutput("t2_rsp_valid", 32'(i_icb.rsp_valid), 32'd1);
    checkOutput("t2_rsp_err", 32'(i_icb.rsp_err), 32'd1);
    checkOutput("t2_o1_rsp_ready", 32'(o1_icb.rsp_ready), 32'd1);
    tick();
    setRsp1(1'b0, 1'b0, 32'h0);

    // FIFO fill: four accepted, fifth stalls until one pop, no same-cycle bypass
    i_icb.rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 32'h8000_0000 + 32'(k * 4), 32'h0, 4'h0);
      #1;
      checkOutput($sformatf("t3_accept%0d", k), 32'(i_icb.cmd_ready), 32'd1);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 32'h8000_0010, 32'h0, 4'h0);
    #1;
    checkOutput("t3_full_ready", 32'(i_icb.cmd_ready), 32'd0);
    checkOutput("t3_full_o0_valid", 32'(o0_icb.cmd_valid), 32'd0);
    setRsp0(1'b1, 1'b0, 32'hA000_0000);
    i_icb.rsp_ready = 1'b1;
    #1;
    checkOutput("t3_no_bypass", 32'(i_icb.cmd_ready), 32'd0);
    tick();
    setRsp0(1'b0, 1'b0, 32'h0);
    i_icb.rsp_ready = 1'b0;
    #1;
    checkOutput("t3_fifth_ready", 32'(i_icb.cmd_ready), 32'd1);
    checkOutput("t3_fifth_o0_valid", 32'(o0_icb.cmd_valid), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setRsp0(1'b1, 1'b0, 32'hB000_0000);
    i_icb.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("t3_drain%0d", k), 32'(i_icb.rsp_valid), 32'd1);
      tick();
    end
    #1;
    checkOutput("t3_empty_rsp_valid", 32'(i_icb.rsp_valid), 32'd0);
    checkOutput("t3_empty_o0_ready", 32'(o0_icb.rsp_ready), 32'd0);
    setRsp0(1'b0, 1'b0, 32'h0);

    // Target switch blocked while a target-0 command is outstanding
    applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'h0, 4'h0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h1000_0000, 32'h0, 4'h0);
    #1;
    checkOutput("t4_switch_ready", 32'(i_icb.cmd_ready), 32'd0);
    checkOutput("t4_switch_o1_valid", 32'(o1_icb.cmd_valid), 32'd0);
    setRsp0(1'b1, 1'b0, 32'h5555_0000);
    #1;
    checkOutput("t4_pop_no_bypass", 32'(i_icb.cmd_ready), 32'd0);
    checkOutput("t4_rsp_rdata", i_icb.rsp_rdata, 32'h5555_0000);
    tick();
    setRsp0(1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("t4_after_ready", 32'(i_icb.cmd_ready), 32'd1);
    checkOutput("t4_after_o1_valid", 32'(o1_icb.cmd_valid), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setRsp1(1'b1, 1'b0, 32'h0000_00AA);
    #1;
    checkOutput("t4_o1_rdata", i_icb.rsp_rdata, 32'h0000_00AA);
    tick();
    setRsp1(1'b0, 1'b0, 32'h0);

    // Unmapped address
    applyStimulus(1'b1, 1'b1, 32'h2000_0000, 32'h0, 4'h0);
    #1;
`ifdef MYRISCV_ICB_SPLT_ERR_EN
    checkOutput("t5_err_o0_valid", 32'(o0_icb.cmd_valid), 32'd0);
    checkOutput("t5_err_o1_valid", 32'(o1_icb.cmd_valid), 32'd0);
    checkOutput("t5_err_ready", 32'(i_icb.cmd_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checkOutput("t5_err_rsp_valid", 32'(i_icb.rsp_valid), 32'd1);
    checkOutput("t5_err_rsp_err", 32'(i_icb.rsp_err), 32'd1);
    checkOutput("t5_err_rsp_rdata", i_icb.rsp_rdata, 32'h0);
    tick();
`else
    checkOutput("t5_dflt_o1_valid", 32'(o1_icb.cmd_valid), 32'd1);
    checkOutput("t5_dflt_o0_valid", 32'(o0_icb.cmd_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setRsp1(1'b1, 1'b0, 32'h0000_0077);
    #1;
    checkOutput("t5_dflt_rdata", i_icb.rsp_rdata, 32'h0000_0077);
    tick();
    setRsp1(1'b0, 1'b0, 32'h0);
`endif
    #1;
    checkOutput("t5_rsp_idle", 32'(i_icb.rsp_valid), 32'd0);

    // Reset with two reads outstanding; the late response must stay blocked
    i_icb.rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h8000_0100, 32'h0, 4'h0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    setRsp0(1'b1, 1'b0, 32'hCAFE_0000);
    #1;
    checkOutput("t6_pre_rsp_valid", 32'(i_icb.rsp_valid), 32'd1);
    rst = 1'b0;
    i_icb.rsp_ready = 1'b1;
    #1;
    checkOutput("t6_rst_rsp_valid", 32'(i_icb.rsp_valid), 32'd0);
    checkOutput("t6_rst_o0_ready", 32'(o0_icb.rsp_ready), 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("t6_post_rsp_valid", 32'(i_icb.rsp_valid), 32'd0);
    checkOutput("t6_post_o0_ready", 32'(o0_icb.rsp_ready), 32'd0);
    checkOutput("t6_post_rdata", i_icb.rsp_rdata, 32'h0);
    setRsp0(1'b0, 1'b0, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
